dm_subword_mem: RTL and testbench
=================================

Name: dm_subword_mem

Overview:
- Parametrised successor of the single-cycle word-only data memory.
- Adds byte and halfword stores through per-lane byte enables.
- Adds sign- or zero-extended sub-word loads, configurable wait-state latency, a req/ready/valid handshake, and error reporting.
- Sits between the MEM-stage load/store unit and backing storage; usable by both the single-cycle and multi-cycle datapaths.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words stored; power of two, at least 4.
- ADDR_W, 12: byte-address width; must satisfy 2^ADDR_W >= DEPTH_WORDS*4.
- WAIT_STATES, 0: extra cycles inserted before each access commits; range 0..15.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous, active-high. Clears control state only.
- req_i  in  1  request strobe; sampled only while ready_o=1.
- we_i  in  1  1 = store, 0 = load.
- size_i  in  2  access size: 00 byte, 01 halfword, 10 word, 11 reserved.
- unsigned_i  in  1  load extension: 1 = zero-extend, 0 = sign-extend. Ignored on stores.
- addr_i  in  ADDR_W  byte address.
- din_i  in  32  store data, right-aligned; only the low 8 or 16 bits are used for byte or halfword stores.
- ready_o  out  1  block idle; a request can be accepted this cycle.
- valid_o  out  1  one-cycle completion pulse.
- dout_o  out  32  extended load data.
- err_o  out  1  access error; qualified by valid_o.

Behaviour:
- Reset values: ready_o=1, valid_o=0, dout_o=0, err_o=0; FSM in IDLE; wait counter 0.
- Memory array is initialised to zero at simulation start and is not cleared by rst.
- FSM states: IDLE, BUSY, RESP.
  - IDLE: ready_o=1. On req_i=1, latch we, size, unsigned, addr and din; load counter with WAIT_STATES; go to BUSY.
  - BUSY: ready_o=0. If counter != 0, decrement it. If counter == 0, commit the access and go to RESP.
  - RESP: valid_o=1 for exactly one cycle, then go to IDLE.
- Timing: if the accepting edge is edge N, valid_o rises at edge N+1+WAIT_STATES and ready_o returns at edge N+2+WAIT_STATES. Peak throughput is one access per WAIT_STATES+3 cycles.
- Word index is addr[ADDR_W-1:2]. Byte lane is addr[1:0], little-endian (lane 0 = bits 7:0).
- Stores:
  - Byte: writes only the addressed lane with din[7:0].
  - Halfword: writes lanes {addr[1],0} and {addr[1],1} with din[15:0].
  - Word: writes all four lanes.
  - Lanes not written are preserved.
- Loads:
  - Extract the addressed byte or halfword, then sign- or zero-extend to 32 bits per unsigned_i.
  - Word loads pass the full word.
  - dout_o registers at commit and holds until the next load completes.
  - Stores leave dout_o unchanged.
- Errors (err_o=1 in RESP):
  - reserved size 11;
  - word index >= DEPTH_WORDS (out of range);
  - misalignment, when trapping is enabled (see Optional Feature).
  - On any error, the store is suppressed, dout_o is unchanged, and valid_o still pulses.
- Boundaries:
  - req_i while BUSY or RESP is ignored; the requester must hold it until it sees ready_o.
  - rst asserted mid-BUSY drops the pending access. A store commits only at the commit edge, so memory is never partially written.
  - A load of the last word (index DEPTH_WORDS-1) is legal.

Optional Feature:
- Macro: DM_MISALIGN_TRAP_EN.
- Defined: halfword with addr[0]=1, or word with addr[1:0]!=0, sets err_o and suppresses the store.
- Undefined: misaligned addresses are force-aligned (halfword clears addr[0], word clears addr[1:0]) and the access proceeds; err_o reports only reserved-size and out-of-range errors.

Decomposition:
- Shared package (dm_pkg):
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - FSM state encodings;
  - constant WAIT_CNT_W=4.
- Sub-module dm_lane_align (combinational): produces the 4-bit byte enable and the lane-shifted write word from size, addr[1:0] and din; also produces the extended load word from the read word, size, addr[1:0] and unsigned.
- The FSM and storage array stay in dm_subword_mem.

Test Plan:
- Word store then load, WAIT_STATES=0: store 0xDEADBEEF to 0x010, then load word from 0x010 -> dout_o=0xDEADBEEF, err_o=0, valid_o rises one edge after accept.
- Sub-word stores: store bytes 0x11 to 0x020, 0x80 to 0x023, then load word from 0x020 -> 0x80000011. Load byte signed from 0x023 -> 0xFFFFFF80; unsigned -> 0x00000080.
- Halfword: store 0xBEEF to 0x032, then load half signed -> 0xFFFFBEEF; word load from 0x030 -> 0xBEEF0000.
- WAIT_STATES=3: count edges from accept to valid_o -> 4; ready_o=0 throughout; a req_i pulse while busy is ignored, with no extra valid_o.
- Errors: size 11 -> err_o=1 and memory unchanged. Word store to 0x002 with the macro defined -> err_o=1 and no write; without the macro -> word written at 0x000.
- Reset mid-BUSY (WAIT_STATES=3): store 0x12345678 to 0x040, assert rst after one cycle -> ready_o=1, valid_o=0, and a later load of 0x040 returns the prior value.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared encodings for the sub-word data memory: access sizes, FSM states, wait-counter width.
package dm_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam int WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;
endpackage

// File: rtl/dm_subword_mem_if.sv
// Request/response bundle between the load/store unit (master) and the data memory (slave).
interface dm_subword_mem_if #(
  parameter int ADDR_W = 12
);
  logic              req_i;
  logic              we_i;
  logic [1:0]        size_i;
  logic              unsigned_i;
  logic [ADDR_W-1:0] addr_i;
  logic [31:0]       din_i;
  logic              ready_o;
  logic              valid_o;
  logic [31:0]       dout_o;
  logic              err_o;

  modport master (
    output req_i, we_i, size_i, unsigned_i, addr_i, din_i,
    input  ready_o, valid_o, dout_o, err_o
  );

  modport slave (
    input  req_i, we_i, size_i, unsigned_i, addr_i, din_i,
    output ready_o, valid_o, dout_o, err_o
  );
endinterface

// File: rtl/dm_lane_align.sv
// Combinational little-endian lane steering: byte enables and replicated store data, plus
// extraction and sign/zero extension of load data. Halfword uses only lane[1]; word ignores lane.
module dm_lane_align
  import dm_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_din,
  input  logic [31:0] i_rd_word,
  input  logic        i_unsigned,
  output logic [3:0]  o_be,
  output logic [31:0] o_wr_word,
  output logic [31:0] o_ld_word
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rd_word[7:0];
    case (i_lane)
      2'd1:    w_byte = i_rd_word[15:8];
      2'd2:    w_byte = i_rd_word[23:16];
      2'd3:    w_byte = i_rd_word[31:24];
      default: w_byte = i_rd_word[7:0];
    endcase
    w_half = i_lane[1] ? i_rd_word[31:16] : i_rd_word[15:0];
  end

  // Store data is replicated across lanes so the byte enable alone selects the target.
  always_comb begin
    o_be      = 4'b0000;
    o_wr_word = i_din;
    o_ld_word = i_rd_word;
    case (i_size)
      SZ_BYTE: begin
        o_be      = 4'b0001 << i_lane;
        o_wr_word = {4{i_din[7:0]}};
        o_ld_word = {{24{~i_unsigned & w_byte[7]}}, w_byte};
      end
      SZ_HALF: begin
        o_be      = i_lane[1] ? 4'b1100 : 4'b0011;
        o_wr_word = {2{i_din[15:0]}};
        o_ld_word = {{16{~i_unsigned & w_half[15]}}, w_half};
      end
      SZ_WORD: begin
        o_be      = 4'b1111;
        o_wr_word = i_din;
        o_ld_word = i_rd_word;
      end
      default: begin
        o_be = 4'b0000;
      end
    endcase
  end
endmodule

// File: rtl/dm_subword_mem.sv
// Byte/half/word data memory, one access per WAIT_STATES+3 cycles; valid_o at accept+1+WAIT_STATES,
// ready_o low while busy (req_i ignored). DM_MISALIGN_TRAP_EN: trap misaligned accesses instead of aligning.
module dm_subword_mem
  import dm_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 12,
  parameter int WAIT_STATES = 0
) (
  input logic             clk,
  input logic             rst,
  dm_subword_mem_if.slave mem
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);

  state_t                r_state;
  state_t                w_next;
  logic [WAIT_CNT_W-1:0] r_cnt;
  logic                  r_we;
  logic                  r_uns;
  logic [1:0]            r_size;
  logic [ADDR_W-1:0]     r_addr;
  logic [31:0]           r_din;
  logic [31:0]           r_dout;
  logic                  r_err;

  // Storage is deliberately outside reset: rst clears control state only.
  logic [31:0] r_mem [DEPTH_WORDS] = '{default: '0};

  logic             w_commit;
  logic             w_oor;
  logic             w_misalign;
  logic             w_err;
  logic [IDX_W-1:0] w_idx;
  logic [3:0]       w_be;
  logic [31:0]      w_wr_word;
  logic [31:0]      w_ld_word;
  logic [31:0]      w_rd_word;

  assign w_idx     = r_addr[IDX_W+1:2];
  assign w_rd_word = r_mem[w_idx];
  assign w_commit  = (r_state == ST_BUSY) && (r_cnt == '0);

  generate
    if (ADDR_W - 2 > IDX_W) begin : g_oor
      assign w_oor = |r_addr[ADDR_W-1:IDX_W+2];
    end else begin : g_no_oor
      assign w_oor = 1'b0;
    end
  endgenerate

`ifdef DM_MISALIGN_TRAP_EN
  assign w_misalign = ((r_size == SZ_HALF) && r_addr[0]) ||
                      ((r_size == SZ_WORD) && (r_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_err = (r_size == SZ_RSVD) || w_oor || w_misalign;

  dm_lane_align u_align (
    .i_size     (r_size),
    .i_lane     (r_addr[1:0]),
    .i_din      (r_din),
    .i_rd_word  (w_rd_word),
    .i_unsigned (r_uns),
    .o_be       (w_be),
    .o_wr_word  (w_wr_word),
    .o_ld_word  (w_ld_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (mem.req_i) w_next = ST_BUSY;
      ST_BUSY: if (r_cnt == '0) w_next = ST_RESP;
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    mem.ready_o = (r_state == ST_IDLE);
    mem.valid_o = (r_state == ST_RESP);
    mem.dout_o  = r_dout;
    mem.err_o   = r_err;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_we   <= 1'b0;
      r_uns  <= 1'b0;
      r_size <= SZ_BYTE;
      r_addr <= '0;
      r_din  <= '0;
      r_dout <= '0;
      r_err  <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE) && mem.req_i) begin
        r_cnt  <= WAIT_CNT_W'(WAIT_STATES);
        r_we   <= mem.we_i;
        r_uns  <= mem.unsigned_i;
        r_size <= mem.size_i;
        r_addr <= mem.addr_i;
        r_din  <= mem.din_i;
      end else if ((r_state == ST_BUSY) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_commit) begin
        r_err <= w_err;
        if (!r_we && !w_err) r_dout <= w_ld_word;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_commit && r_we && !w_err) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wr_word[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_dm_subword_mem.sv
// Directed bench: u0 has no wait states (12-bit address), u3 has three wait states and a
// 13-bit address so that word indices beyond DEPTH_WORDS are reachable.
module tb_dm_subword_mem;
  import dm_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

`ifdef DM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  always #5 clk = ~clk;

  dm_subword_mem_if #(.ADDR_W(12)) if0 ();
  dm_subword_mem_if #(.ADDR_W(13)) if3 ();

  dm_subword_mem #(.DEPTH_WORDS(1024), .ADDR_W(12), .WAIT_STATES(0)) u0 (
    .clk (clk), .rst (rst), .mem (if0)
  );
  dm_subword_mem #(.DEPTH_WORDS(1024), .ADDR_W(13), .WAIT_STATES(3)) u3 (
    .clk (clk), .rst (rst), .mem (if3)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic drive_idle();
    if0.req_i = 1'b0; if0.we_i = 1'b0; if0.size_i = SZ_WORD; if0.unsigned_i = 1'b0;
    if0.addr_i = '0;  if0.din_i = '0;
    if3.req_i = 1'b0; if3.we_i = 1'b0; if3.size_i = SZ_WORD; if3.unsigned_i = 1'b0;
    if3.addr_i = '0;  if3.din_i = '0;
  endtask

  // One complete access; returns data/error at the valid_o cycle and the edge count from accept.
  task automatic do_access(input bit sel, input bit we, input logic [1:0] size, input bit uns,
                           input logic [12:0] addr, input logic [31:0] din,
                           output logic [31:0] dout, output logic err, output int cyc,
                           output bit rdy_seen);
    logic vld;
    @(negedge clk);
    if (!sel) begin
      if0.req_i = 1'b1; if0.we_i = we; if0.size_i = size; if0.unsigned_i = uns;
      if0.addr_i = addr[11:0]; if0.din_i = din;
    end else begin
      if3.req_i = 1'b1; if3.we_i = we; if3.size_i = size; if3.unsigned_i = uns;
      if3.addr_i = addr; if3.din_i = din;
    end
    @(posedge clk); #1;
    if0.req_i = 1'b0;
    if3.req_i = 1'b0;
    cyc = 0;
    rdy_seen = 1'b0;
    do begin
      @(posedge clk); #1;
      cyc++;
      if ((sel ? if3.ready_o : if0.ready_o) === 1'b1) rdy_seen = 1'b1;
      vld = sel ? if3.valid_o : if0.valid_o;
    end while (vld !== 1'b1 && cyc < 40);
    if (vld !== 1'b1) begin
      n_tests++; n_fail++;
      $display("FAIL timeout: no valid_o within %0d edges (addr %h)", cyc, addr);
    end
    dout = sel ? if3.dout_o : if0.dout_o;
    err  = sel ? if3.err_o  : if0.err_o;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    if (if0.ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready0: got %b want 1", if0.ready_o); end
    n_tests++;
    if (if0.valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid0: got %b want 0", if0.valid_o); end
    n_tests++;
    if (if0.dout_o !== 32'h0) begin n_fail++; $display("FAIL reset_dout0: got %h want 0", if0.dout_o); end
    n_tests++;
    if (if0.err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err0: got %b want 0", if0.err_o); end
    n_tests++;
    if (if3.ready_o !== 1'b1 || if3.valid_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_u3: ready %b valid %b want 1 0", if3.ready_o, if3.valid_o);
    end
    n_tests++;
    rst = 1'b0;
  endtask

  task automatic test_word();
    logic [31:0] d; logic e; int c; bit r;
    do_access(1'b0, 1'b1, SZ_WORD, 1'b0, 13'h010, 32'hDEADBEEF, d, e, c, r);
    if (e !== 1'b0 || c != 1) begin n_fail++; $display("FAIL word_store: err %b edges %0d want 0 1", e, c); end
    n_tests++;
    do_access(1'b0, 1'b0, SZ_WORD, 1'b0, 13'h010, 32'h0, d, e, c, r);
    if (d !== 32'hDEADBEEF) begin n_fail++; $display("FAIL word_load: got %h want deadbeef", d); end
    n_tests++;
    if (e !== 1'b0 || c != 1) begin n_fail++; $display("FAIL word_load_timing: err %b edges %0d want 0 1", e, c); end
    n_tests++;
  endtask

  task automatic test_subword();
    logic [31:0] d; logic e; int c; bit r;
    do_access(1'b0, 1'b1, SZ_BYTE, 1'b0, 13'h020, 32'hFFFFFF11, d, e, c, r);
    do_access(1'b0, 1'b1, SZ_BYTE, 1'b0, 13'h023, 32'hABCDEF80, d, e, c, r);
    do_access(1'b0, 1'b0, SZ_WORD, 1'b0, 13'h020, 32'h0, d, e, c, r);
    if (d !== 32'h80000011) begin n_fail++; $display("FAIL byte_store_word: got %h want 80000011", d); end
    n_tests++;
    do_access(1'b0, 1'b0, SZ_BYTE, 1'b0, 13'h023, 32'h0, d, e, c, r);
    if (d !== 32'hFFFFFF80) begin n_fail++; $display("FAIL byte_load_signed: got %h want ffffff80", d); end
    n_tests++;
    do_access(1'b0, 1'b0, SZ_BYTE, 1'b1, 13'h023, 32'h0, d, e, c, r);
    if (d !== 32'h00000080) begin n_fail++; $display("FAIL byte_load_unsigned: got %h want 00000080", d); end
    n_tests++;
    do_access(1'b0, 1'b0, SZ_BYTE, 1'b0, 13'h020, 32'h0, d, e, c, r);
    if (d !== 32'h00000011) begin n_fail++; $display("FAIL byte_load_lane0: got %h want 00000011", d); end
    n_tests++;
  endtask

  task automatic test_half();
    logic [31:0] d; logic e; int c; bit r;
    do_access(1'b0, 1'b1, SZ_HALF, 1'b0, 13'h032, 32'h1234BEEF, d, e, c, r);
    do_access(1'b0, 1'b0, SZ_HALF, 1'b0, 13'h032, 32'h0, d, e, c, r);
    if (d !== 32'hFFFFBEEF) begin n_fail++; $display("FAIL half_load_signed: got %h want ffffbeef", d); end
    n_tests++;
    do_access(1'b0, 1'b0, SZ_HALF, 1'b1, 13'h032, 32'h0, d, e, c, r);
    if (d !== 32'h0000BEEF) begin n_fail++; $display("FAIL half_load_unsigned: got %h want 0000beef", d); end
    n_tests++;
    do_access(1'b0, 1'b0, SZ_WORD, 1'b0, 13'h030, 32'h0, d, e, c, r);
    if (d !== 32'hBEEF0000) begin n_fail++; $display("FAIL half_store_word: got %h want beef0000", d); end
    n_tests++;
  endtask

  task automatic test_errors();
    logic [31:0] d; logic e; int c; bit r;
    logic [31:0] exp_w;
    do_access(1'b0, 1'b1, SZ_WORD, 1'b0, 13'h050, 32'hCAFEF00D, d, e, c, r);
    do_access(1'b0, 1'b1, SZ_RSVD, 1'b0, 13'h050, 32'hFFFFFFFF, d, e, c, r);
    if (e !== 1'b1) begin n_fail++; $display("FAIL rsvd_store_err: got %b want 1", e); end
    n_tests++;
    do_access(1'b0, 1'b0, SZ_WORD, 1'b0, 13'h050, 32'h0, d, e, c, r);
    if (d !== 32'hCAFEF00D || e !== 1'b0) begin
      n_fail++; $display("FAIL rsvd_mem_kept: got %h err %b want cafef00d 0", d, e);
    end
    n_tests++;
    do_access(1'b0, 1'b0, SZ_RSVD, 1'b0, 13'h010, 32'h0, d, e, c, r);
    if (e !== 1'b1 || d !== 32'hCAFEF00D) begin
      n_fail++; $display("FAIL rsvd_load: got %h err %b want cafef00d 1", d, e);
    end
    n_tests++;
    do_access(1'b0, 1'b1, SZ_WORD, 1'b0, 13'h002, 32'h01020304, d, e, c, r);
    if (e !== TRAP) begin n_fail++; $display("FAIL misalign_err: got %b want %b", e, TRAP); end
    n_tests++;
    exp_w = TRAP ? 32'h0 : 32'h01020304;
    do_access(1'b0, 1'b0, SZ_WORD, 1'b0, 13'h000, 32'h0, d, e, c, r);
    if (d !== exp_w) begin n_fail++; $display("FAIL misalign_mem: got %h want %h", d, exp_w); end
    n_tests++;
  endtask

  task automatic test_wait_states();
    logic [31:0] d; logic e; int c; bit r;
    do_access(1'b1, 1'b1, SZ_WORD, 1'b0, 13'h070, 32'h0BADF00D, d, e, c, r);
    if (c != 4 || r !== 1'b0) begin n_fail++; $display("FAIL ws_store: edges %0d ready_seen %b want 4 0", c, r); end
    n_tests++;
    do_access(1'b1, 1'b0, SZ_WORD, 1'b0, 13'h070, 32'h0, d, e, c, r);
    if (d !== 32'h0BADF00D || c != 4) begin
      n_fail++; $display("FAIL ws_load: got %h edges %0d want 0badf00d 4", d, c);
    end
    n_tests++;
    do_access(1'b1, 1'b0, SZ_WORD, 1'b0, 13'h1000, 32'h0, d, e, c, r);
    if (e !== 1'b1 || d !== 32'h0BADF00D) begin
      n_fail++; $display("FAIL oor_load: got %h err %b want 0badf00d 1", d, e);
    end
    n_tests++;
    do_access(1'b1, 1'b1, SZ_WORD, 1'b0, 13'h1000, 32'h55555555, d, e, c, r);
    if (e !== 1'b1) begin n_fail++; $display("FAIL oor_store_err: got %b want 1", e); end
    n_tests++;
    do_access(1'b1, 1'b0, SZ_WORD, 1'b0, 13'h000, 32'h0, d, e, c, r);
    if (d !== 32'h0 || e !== 1'b0) begin n_fail++; $display("FAIL oor_no_alias: got %h err %b want 0 0", d, e); end
    n_tests++;
    do_access(1'b1, 1'b0, SZ_WORD, 1'b0, 13'h0FFC, 32'h0, d, e, c, r);
    if (e !== 1'b0 || d !== 32'h0) begin n_fail++; $display("FAIL last_word: got %h err %b want 0 0", d, e); end
    n_tests++;
  endtask

  task automatic test_busy_req();
    logic [31:0] d; logic e; int c; bit r;
    int n_vld;
    bit early_rdy;
    @(negedge clk);
    if3.req_i = 1'b1; if3.we_i = 1'b1; if3.size_i = SZ_WORD; if3.addr_i = 13'h080;
    if3.din_i = 32'h11112222;
    @(posedge clk); #1;
    if3.addr_i = 13'h060; if3.din_i = 32'h77777777;
    n_vld = 0;
    early_rdy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (i == 1) if3.req_i = 1'b0;
      if (if3.valid_o === 1'b1) n_vld++;
      if (n_vld == 0 && if3.ready_o === 1'b1) early_rdy = 1'b1;
    end
    if (n_vld != 1) begin n_fail++; $display("FAIL busy_req_valids: got %0d want 1", n_vld); end
    n_tests++;
    if (early_rdy) begin n_fail++; $display("FAIL busy_ready: got ready=1 before valid, want 0"); end
    n_tests++;
    do_access(1'b1, 1'b0, SZ_WORD, 1'b0, 13'h060, 32'h0, d, e, c, r);
    if (d !== 32'h0) begin n_fail++; $display("FAIL busy_req_ignored: got %h want 0", d); end
    n_tests++;
    do_access(1'b1, 1'b0, SZ_WORD, 1'b0, 13'h080, 32'h0, d, e, c, r);
    if (d !== 32'h11112222) begin n_fail++; $display("FAIL busy_first_store: got %h want 11112222", d); end
    n_tests++;
  endtask

  task automatic test_reset_busy();
    logic [31:0] d; logic e; int c; bit r;
    int n_vld;
    do_access(1'b1, 1'b1, SZ_WORD, 1'b0, 13'h040, 32'hAAAA5555, d, e, c, r);
    @(negedge clk);
    if3.req_i = 1'b1; if3.we_i = 1'b1; if3.size_i = SZ_WORD; if3.addr_i = 13'h040;
    if3.din_i = 32'h12345678;
    @(posedge clk); #1;
    if3.req_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    if (if3.ready_o !== 1'b1 || if3.valid_o !== 1'b0) begin
      n_fail++; $display("FAIL rst_busy_outputs: ready %b valid %b want 1 0", if3.ready_o, if3.valid_o);
    end
    n_tests++;
    @(negedge clk);
    rst = 1'b0;
    n_vld = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (if3.valid_o === 1'b1) n_vld++;
    end
    if (n_vld != 0) begin n_fail++; $display("FAIL rst_busy_no_valid: got %0d want 0", n_vld); end
    n_tests++;
    do_access(1'b1, 1'b0, SZ_WORD, 1'b0, 13'h040, 32'h0, d, e, c, r);
    if (d !== 32'hAAAA5555) begin n_fail++; $display("FAIL rst_busy_mem: got %h want aaaa5555", d); end
    n_tests++;
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_word();
    test_subword();
    test_half();
    test_errors();
    test_wait_states();
    test_busy_req();
    test_reset_busy();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
